// File: rtl/mem_pkg.sv
// Shared types and elaboration helpers for the strobed slave memory.
// Imported by the controller and its storage array.
package mem_pkg;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } mem_state_t;

  // The byte-strobe scheme only works when the data word is whole bytes.
  function automatic bit width_is_byte_multiple(input int unsigned w);
    return ((w % 32'd8) == 32'd0) && (w != 32'd0);
  endfunction

endpackage

// File: rtl/byte_en_ram.sv
// Single-port storage array with per-byte write enables and a registered read port.
// The array is deliberately not reset; the controller clears it with a sweep.
module byte_en_ram #(
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 64,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int STRB_WIDTH = WIDTH / 8
) (
  input  logic                  clk_i,
  input  logic [STRB_WIDTH-1:0] we,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [WIDTH-1:0]      wdata,
  output logic [WIDTH-1:0]      rdata
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [WIDTH-1:0] rdata_r;

  // Byte-lane writes and read-enabled capture; read data only moves on a read.
  always_ff @(posedge clk_i) begin
    for (int k = 0; k < STRB_WIDTH; k++) begin
      if (we[k]) begin
        mem_r[addr][8*k +: 8] <= wdata[8*k +: 8];
      end
    end
    if (re) begin
      rdata_r <= mem_r[addr];
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/mem_strb_ctrl.sv
// Valid/ready slave memory with byte strobes, range checking and a post-reset
// clear sweep; every accepted request yields exactly one in-order response.
module mem_strb_ctrl
  import mem_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 64,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int STRB_WIDTH = WIDTH / 8,
  parameter int INIT_CLEAR = 1
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic                  wr_rd_i,
  input  logic [WIDTH-1:0]      wdata_i,
  input  logic [STRB_WIDTH-1:0] wstrb_i,
  output logic                  rvalid_o,
  input  logic                  rready_i,
  output logic [WIDTH-1:0]      rdata_o,
  output logic                  err_o,
  output logic                  init_done_o
);

  if (!width_is_byte_multiple(WIDTH)) begin : g_bad_width
    $error("mem_strb_ctrl: WIDTH must be a non-zero multiple of 8");
  end

  localparam logic [ADDR_WIDTH:0]   DEPTH_L   = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);

  mem_state_t              state_r;
  mem_state_t              state_s;
  logic [ADDR_WIDTH-1:0]   cnt_r;
  logic                    init_done_r;
  logic                    rvalid_r;
  logic                    err_r;
  logic                    rsp_rd_r;
  logic                    ready_s;
  logic                    accept_s;
  logic                    in_range_s;
  logic [STRB_WIDTH-1:0]   ram_we_s;
  logic                    ram_re_s;
  logic [ADDR_WIDTH-1:0]   ram_addr_s;
  logic [WIDTH-1:0]        ram_wdata_s;
  logic [WIDTH-1:0]        ram_q_s;

  // A stalled response blocks new requests so responses never get overwritten.
  assign ready_s    = (state_r == ST_RUN) && (!rvalid_r || rready_i);
  assign accept_s   = valid_i && ready_s;
  assign in_range_s = ({1'b0, addr_i} < DEPTH_L);

  // State register.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_r <= ST_INIT;
    end else begin
      state_r <= state_s;
    end
  end

  // Next state and RAM port control; the sweep owns the port while in INIT.
  always_comb begin
    state_s     = state_r;
    ram_we_s    = {STRB_WIDTH{1'b0}};
    ram_re_s    = 1'b0;
    ram_addr_s  = addr_i;
    ram_wdata_s = wdata_i;
    case (state_r)
      ST_INIT: begin
        ram_addr_s  = cnt_r;
        ram_wdata_s = {WIDTH{1'b0}};
        if (INIT_CLEAR != 0) begin
          ram_we_s = {STRB_WIDTH{1'b1}};
          if (cnt_r == LAST_ADDR) begin
            state_s = ST_RUN;
          end else begin
            state_s = ST_INIT;
          end
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_RUN: begin
        if (accept_s && in_range_s) begin
          if (wr_rd_i) begin
            ram_we_s = wstrb_i;
          end else begin
            ram_re_s = 1'b1;
          end
        end else begin
          ram_we_s = {STRB_WIDTH{1'b0}};
        end
      end
      default: begin
        state_s = ST_INIT;
      end
    endcase
  end

  // Sweep counter and registered decode of the RUN state.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      cnt_r       <= {ADDR_WIDTH{1'b0}};
      init_done_r <= 1'b0;
    end else begin
      init_done_r <= (state_s == ST_RUN);
      if ((state_r == ST_INIT) && (INIT_CLEAR != 0)) begin
        cnt_r <= cnt_r + ADDR_ONE;
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

  // Response register: load on accept, hold while stalled, drain on rready.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      rvalid_r <= 1'b0;
      err_r    <= 1'b0;
      rsp_rd_r <= 1'b0;
    end else if (accept_s) begin
      rvalid_r <= 1'b1;
      err_r    <= !in_range_s;
      rsp_rd_r <= in_range_s && !wr_rd_i;
    end else if (rready_i) begin
      rvalid_r <= 1'b0;
      err_r    <= 1'b0;
      rsp_rd_r <= 1'b0;
    end else begin
      rvalid_r <= rvalid_r;
      err_r    <= err_r;
      rsp_rd_r <= rsp_rd_r;
    end
  end

  byte_en_ram #(
    .WIDTH      (WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .STRB_WIDTH (STRB_WIDTH)
  ) u_ram (
    .clk_i (clk_i),
    .we    (ram_we_s),
    .re    (ram_re_s),
    .addr  (ram_addr_s),
    .wdata (ram_wdata_s),
    .rdata (ram_q_s)
  );

  // Read data is gated by a reset flop, so it drops to zero immediately on reset.
  assign ready_o     = ready_s;
  assign rvalid_o    = rvalid_r;
  assign err_o       = err_r;
  assign rdata_o     = rsp_rd_r ? ram_q_s : {WIDTH{1'b0}};
  assign init_done_o = init_done_r;

endmodule

// File: tb/tb_mem_strb_ctrl.sv
// Directed bench for mem_strb_ctrl: a DEPTH=64 and a DEPTH=48 instance share
// request inputs; each scenario task checks hand-computed responses inline.
module tb_mem_strb_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid;
  logic [5:0]  addr;
  logic        wr_rd;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        rready;

  logic        ready64, rvalid64, err64, done64;
  logic [31:0] rdata64;
  logic        ready48, rvalid48, err48, done48;
  logic [31:0] rdata48;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_strb_ctrl #(.WIDTH(32), .DEPTH(64), .INIT_CLEAR(1)) dut (
    .clk_i(clk), .reset_i(rst_n), .valid_i(valid), .ready_o(ready64),
    .addr_i(addr), .wr_rd_i(wr_rd), .wdata_i(wdata), .wstrb_i(wstrb),
    .rvalid_o(rvalid64), .rready_i(rready), .rdata_o(rdata64),
    .err_o(err64), .init_done_o(done64)
  );

  mem_strb_ctrl #(.WIDTH(32), .DEPTH(48), .INIT_CLEAR(1)) dut48 (
    .clk_i(clk), .reset_i(rst_n), .valid_i(valid), .ready_o(ready48),
    .addr_i(addr), .wr_rd_i(wr_rd), .wdata_i(wdata), .wstrb_i(wstrb),
    .rvalid_o(rvalid48), .rready_i(rready), .rdata_o(rdata48),
    .err_o(err48), .init_done_o(done48)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic wr, input logic [5:0] a, input logic [31:0] d,
                      input logic [3:0] s);
    valid = 1'b1; wr_rd = wr; addr = a; wdata = d; wstrb = s;
    tick();
    valid = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if ({ready64, rvalid64, err64, done64, rdata64} !== 36'd0) begin
      errors++;
      $display("FAIL reset_outputs: got rdy=%b rv=%b err=%b done=%b rdata=%h, want all 0",
               ready64, rvalid64, err64, done64, rdata64);
    end
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 64; i++) begin
      checks++;
      if (ready64 !== 1'b0 || done64 !== 1'b0) begin
        errors++;
        $display("FAIL sweep_cycle%0d: got rdy=%b done=%b, want 0 0", i, ready64, done64);
      end
      tick();
    end
    checks++;
    if (ready64 !== 1'b1 || done64 !== 1'b1) begin
      errors++;
      $display("FAIL sweep_done: got rdy=%b done=%b, want 1 1", ready64, done64);
    end
    checks++;
    if (ready48 !== 1'b1 || done48 !== 1'b1) begin
      errors++;
      $display("FAIL sweep_done48: got rdy=%b done=%b, want 1 1", ready48, done48);
    end
  endtask

  task automatic test_cleared_reads();
    logic [5:0] addrs [3];
    addrs[0] = 6'd0; addrs[1] = 6'd31; addrs[2] = 6'd63;
    for (int i = 0; i < 3; i++) begin
      send(1'b0, addrs[i], 32'h0, 4'h0);
      checks++;
      if (rvalid64 !== 1'b1 || rdata64 !== 32'h0 || err64 !== 1'b0) begin
        errors++;
        $display("FAIL clear_read_a%0d: got rv=%b rdata=%h err=%b, want 1 00000000 0",
                 addrs[i], rvalid64, rdata64, err64);
      end
    end
    tick();
  endtask

  task automatic test_strobes();
    send(1'b1, 6'd5, 32'hDEADBEEF, 4'hF);
    checks++;
    if (rvalid64 !== 1'b1 || rdata64 !== 32'h0 || err64 !== 1'b0) begin
      errors++;
      $display("FAIL wr_full_rsp: got rv=%b rdata=%h err=%b, want 1 00000000 0",
               rvalid64, rdata64, err64);
    end
    send(1'b1, 6'd5, 32'h11223344, 4'b0101);
    checks++;
    if (rvalid64 !== 1'b1 || rdata64 !== 32'h0 || err64 !== 1'b0) begin
      errors++;
      $display("FAIL wr_strb_rsp: got rv=%b rdata=%h err=%b, want 1 00000000 0",
               rvalid64, rdata64, err64);
    end
    send(1'b1, 6'd5, 32'hFFFFFFFF, 4'h0);
    checks++;
    if (rvalid64 !== 1'b1 || err64 !== 1'b0) begin
      errors++;
      $display("FAIL wr_nop_rsp: got rv=%b err=%b, want 1 0", rvalid64, err64);
    end
    send(1'b0, 6'd5, 32'h0, 4'h0);
    checks++;
    if (rvalid64 !== 1'b1 || rdata64 !== 32'hDE22BE44 || err64 !== 1'b0) begin
      errors++;
      $display("FAIL strb_readback: got rv=%b rdata=%h err=%b, want 1 de22be44 0",
               rvalid64, rdata64, err64);
    end
    tick();
    checks++;
    if (rvalid64 !== 1'b0) begin
      errors++;
      $display("FAIL rsp_drain: got rv=%b, want 0", rvalid64);
    end
  endtask

  task automatic test_range();
    send(1'b1, 6'd47, 32'hAABBCCDD, 4'hF);
    send(1'b0, 6'd50, 32'h0, 4'h0);
    checks++;
    if (rvalid48 !== 1'b1 || err48 !== 1'b1 || rdata48 !== 32'h0) begin
      errors++;
      $display("FAIL oor_read: got rv=%b err=%b rdata=%h, want 1 1 00000000",
               rvalid48, err48, rdata48);
    end
    send(1'b1, 6'd47, 32'h12345678, 4'h0);
    checks++;
    if (rvalid48 !== 1'b1 || err48 !== 1'b0 || rdata48 !== 32'h0) begin
      errors++;
      $display("FAIL inrange_write: got rv=%b err=%b rdata=%h, want 1 0 00000000",
               rvalid48, err48, rdata48);
    end
    send(1'b1, 6'd63, 32'h55555555, 4'hF);
    checks++;
    if (err48 !== 1'b1 || err64 !== 1'b0) begin
      errors++;
      $display("FAIL oor_write: got err48=%b err64=%b, want 1 0", err48, err64);
    end
    send(1'b0, 6'd47, 32'h0, 4'h0);
    checks++;
    if (rdata48 !== 32'hAABBCCDD || err48 !== 1'b0) begin
      errors++;
      $display("FAIL range_readback: got rdata=%h err=%b, want aabbccdd 0", rdata48, err48);
    end
    tick();
  endtask

  task automatic test_stall();
    rready = 1'b0;
    send(1'b0, 6'd5, 32'h0, 4'h0);
    valid = 1'b1; wr_rd = 1'b0; addr = 6'd6;
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (rvalid64 !== 1'b1 || rdata64 !== 32'hDE22BE44 || ready64 !== 1'b0) begin
        errors++;
        $display("FAIL stall_cycle%0d: got rv=%b rdata=%h rdy=%b, want 1 de22be44 0",
                 i, rvalid64, rdata64, ready64);
      end
      tick();
    end
    rready = 1'b1;
    #1;
    checks++;
    if (ready64 !== 1'b1) begin
      errors++;
      $display("FAIL stall_release_ready: got %b, want 1", ready64);
    end
    tick();
    valid = 1'b0;
    checks++;
    if (rvalid64 !== 1'b1 || rdata64 !== 32'h0 || err64 !== 1'b0) begin
      errors++;
      $display("FAIL stall_next_rsp: got rv=%b rdata=%h err=%b, want 1 00000000 0",
               rvalid64, rdata64, err64);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 16; i++) begin
      valid = 1'b1; wr_rd = (i < 8); addr = 6'(i % 8);
      wdata = 32'(i % 8) * 32'h01010101; wstrb = 4'hF;
      checks++;
      if (ready64 !== 1'b1) begin
        errors++;
        $display("FAIL stream_ready%0d: got %b, want 1", i, ready64);
      end
      tick();
      checks++;
      if (rvalid64 !== 1'b1 || err64 !== 1'b0 ||
          rdata64 !== ((i < 8) ? 32'h0 : 32'(i % 8) * 32'h01010101)) begin
        errors++;
        $display("FAIL stream_rsp%0d: got rv=%b err=%b rdata=%h", i, rvalid64, err64, rdata64);
      end
    end
    valid = 1'b0;
    tick();
    checks++;
    if (rvalid64 !== 1'b0) begin
      errors++;
      $display("FAIL stream_drain: got rv=%b, want 0", rvalid64);
    end
  endtask

  task automatic test_reset_mid();
    rready = 1'b0;
    send(1'b0, 6'd5, 32'h0, 4'h0);
    checks++;
    if (rvalid64 !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_pending: got rv=%b, want 1", rvalid64);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({ready64, rvalid64, err64, done64, rdata64} !== 36'd0) begin
      errors++;
      $display("FAIL async_reset: got rdy=%b rv=%b err=%b done=%b rdata=%h, want all 0",
               ready64, rvalid64, err64, done64, rdata64);
    end
    tick();
    rst_n = 1'b1;
    rready = 1'b1;
    for (int i = 0; i < 64; i++) begin
      checks++;
      if (rvalid64 !== 1'b0 || ready64 !== 1'b0) begin
        errors++;
        $display("FAIL resweep_cycle%0d: got rv=%b rdy=%b, want 0 0", i, rvalid64, ready64);
      end
      tick();
    end
    checks++;
    if (done64 !== 1'b1 || rvalid64 !== 1'b0) begin
      errors++;
      $display("FAIL resweep_done: got done=%b rv=%b, want 1 0", done64, rvalid64);
    end
    send(1'b0, 6'd5, 32'h0, 4'h0);
    checks++;
    if (rvalid64 !== 1'b1 || rdata64 !== 32'h0) begin
      errors++;
      $display("FAIL resweep_cleared: got rv=%b rdata=%h, want 1 00000000", rvalid64, rdata64);
    end
    tick();
  endtask

  initial begin
    rst_n = 1'b1; valid = 1'b0; addr = 6'd0; wr_rd = 1'b0;
    wdata = 32'h0; wstrb = 4'h0; rready = 1'b1;
    #1 rst_n = 1'b0;
    @(posedge clk);
    #2;
    test_reset();
    test_cleared_reads();
    test_strobes();
    test_range();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_strb_ctrl.md
# mem_strb_ctrl

Parametrised single-port on-chip memory with a valid/ready request channel, a back-pressured response channel, per-byte write strobes, out-of-range address detection and a hardware clear sweep after reset. It replaces the fixed 16x64 memory as the generic slave memory behind any master that speaks valid/ready. Every accepted request returns exactly one response, reads and writes alike, in order, with one-cycle latency.

## Interface
- WIDTH, 32, data width in bits; must be a multiple of 8
- DEPTH, 64, number of words; need not be a power of two
- ADDR_WIDTH, $clog2(DEPTH), address width
- STRB_WIDTH, WIDTH/8, byte strobe width
- INIT_CLEAR, 1, 1 = zero every word after reset; 0 = skip the sweep, contents undefined

- clk_i  in  1  single clock, all logic on rising edge
- reset_i  in  1  asynchronous, active-low reset
- valid_i  in  1  request valid
- ready_o  out  1  request accepted when valid_i && ready_o
- addr_i  in  ADDR_WIDTH  word address
- wr_rd_i  in  1  1 = write, 0 = read
- wdata_i  in  WIDTH  write data
- wstrb_i  in  STRB_WIDTH  byte enables; bit k covers wdata_i[8k+7:8k]
- rvalid_o  out  1  response valid
- rready_i  in  1  response consumed when rvalid_o && rready_i
- rdata_o  out  WIDTH  read data; 0 for write responses and error responses
- err_o  out  1  response flag: addr_i >= DEPTH
- init_done_o  out  1  high once the clear sweep is finished

## Operation
- States: INIT, RUN.
- On reset assertion: state = INIT, sweep counter = 0. ready_o, rvalid_o, err_o, rdata_o and init_done_o all go to 0. The memory array is not reset.
- INIT with INIT_CLEAR=1: each cycle writes all-zero to word[counter], then increments the counter. After word DEPTH-1 is written, go to RUN. ready_o = 0 throughout.
- INIT with INIT_CLEAR=0: go to RUN on the first clock after reset release.
- init_done_o = (state == RUN), registered.
- ready_o = RUN && (!rvalid_o || rready_i). This is combinational, so full throughput is possible when rready_i is held high.
- Accepted write, address in range: for each k with wstrb_i[k]=1, byte k of word[addr_i] takes the matching byte of wdata_i. Other bytes are unchanged. The response is rdata_o=0, err_o=0.
- wstrb_i = 0 is a legal no-op write and still gets a response.
- Accepted read, address in range: the response carries word[addr_i] as it was before this edge, with err_o=0.
- Accepted request with addr_i >= DEPTH: no memory access. The response is rdata_o=0, err_o=1.
- Response register: loads on acceptance. If rvalid_o && !rready_i, it holds rvalid_o, rdata_o and err_o stable. If rready_i is high and no new request is accepted, rvalid_o clears.
- Write at edge N followed by a read of the same address at edge N+1: the read returns the written data.
- Reset mid-transaction: the pending response is discarded and no response is ever produced for it. The sweep restarts from 0.

## Timing
- Request accepted at edge N: rvalid_o is high from after edge N until the first edge where rready_i=1.
- Back-to-back throughput: 1 request per cycle while rready_i=1.
- Stall: while rvalid_o=1 and rready_i=0, ready_o=0 in the same cycle.
- Clear sweep: DEPTH cycles after reset release. init_done_o and the first possible ready_o are high in cycle DEPTH+1.
- Reset is asynchronous assert, synchronous release. Outputs are 0 immediately on assertion.

## Structure
- Package mem_pkg:
  - state enum mem_state_t {ST_INIT, ST_RUN}
  - WIDTH%8==0 check helper
- Sub-module byte_en_ram:
  - storage array, DEPTH x WIDTH
  - synchronous read, per-byte write enable
  - no reset
  - instantiated once
- Top level holds:
  - FSM
  - sweep counter
  - address range check
  - response register
  - handshake logic

## Test plan
- Reset release with INIT_CLEAR=1, DEPTH=64: ready_o=0 for 64 cycles, init_done_o=1 in cycle 65. Reads of addresses 0, 31 and 63 return 0x00000000 with err_o=0.
- Write 0xDEADBEEF to addr 5 with wstrb 4'hF, then write 0x11223344 to addr 5 with wstrb 4'b0101. Read addr 5 returns 0xDE22BE44. Both writes respond with rdata_o=0, err_o=0.
- DEPTH=48: read addr 50 and write addr 47 -> first response err_o=1, rdata_o=0, memory unchanged; second response err_o=0.
- Hold rready_i=0 after a read of addr 5 (0xDE22BE44): rvalid_o stays 1, rdata_o stays stable, ready_o=0 for 10 cycles. Raise rready_i: the response is consumed and ready_o=1 in the same cycle.
- Streaming, rready_i=1: write addrs 0..7 with data i*0x01010101 on consecutive cycles, then read them back. Expect 16 responses in 16 consecutive cycles with correct data and no bubbles.
- Assert reset_i=0 while a read response is stalled: all outputs are 0 immediately. After release, the sweep reruns and the stale response never appears.
